instr_fetch_unit: RTL

- Fetch stage of the multi-cycle MIPS32 core. It sits directly downstream of the instruction ROM and upstream of the control unit and decode.
- Owns the PC and drives the ROM's active-low chip enable, read enable and 9-bit address. It captures the ROM word into the instruction register (IR).
- On control-unit request it performs one fetch, advances the PC by 4, and flags misaligned or out-of-range PCs instead of issuing a ROM access.

---
 rtl/instr_fetch_unit_pkg.sv | 19 +
 rtl/instr_fetch_unit_if.sv | 12 +
 rtl/instr_fetch_unit.sv | 78 +++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared state encoding, constants and fetch-address check for the fetch stage.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_READ  = 2'd1,
        IF_DONE  = 2'd2,
        IF_FAULT = 2'd3
    } if_state_e;

    localparam logic [31:0] PC_INC = 32'd4;
    localparam int ROM_AWIDTH_DEF = 9;

    // A fetch PC is legal only when word aligned and fully addressable by the ROM.
    function automatic logic fetch_ok(input logic [31:0] addr, input int aw);
        return (addr[1:0] == 2'b00) && ((addr >> aw) == 32'd0);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction ROM bus between the fetch unit (master) and the ROM (slave).
interface instr_fetch_unit_if #(
    parameter int AWIDTH = 9
);
    logic              rom_nce;
    logic              rom_re;
    logic [AWIDTH-1:0] rom_addr;
    logic [31:0]       rom_data;

    modport master (output rom_nce, output rom_re, output rom_addr, input rom_data);
    modport slave  (input rom_nce, input rom_re, input rom_addr, output rom_data);
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, reads one ROM word per request into the IR and traps bad fetch addresses.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1,
    parameter int          ROM_AWIDTH  = ROM_AWIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fetch_start,
    input  logic                      pc_we,
    input  logic [31:0]               pc_next,
    instr_fetch_unit_if.master        rom,
    output logic [31:0]               ir,
    output logic [31:0]               pc,
    output logic [31:0]               pc_plus4,
    output logic                      busy,
    output logic                      ir_valid,
    output logic                      fault
);

    if_state_e   state, state_nx;
    logic [2:0]  cnt;
    logic        redir;
    logic [31:0] redir_pc;
    logic [31:0] fetch_pc;
    logic        read_last;

    always_comb begin
        fetch_pc  = pc_we ? pc_next : pc;
        read_last = (state == IF_READ) && (cnt == 3'(WAIT_CYCLES - 1));
        state_nx  = IF_IDLE;
        case (state)
            IF_IDLE, IF_DONE: state_nx = !fetch_start ? IF_IDLE :
                                         fetch_ok(fetch_pc, ROM_AWIDTH) ? IF_READ : IF_FAULT;
            IF_READ:          state_nx = read_last ? IF_DONE : IF_READ;
            IF_FAULT:         state_nx = pc_we ? IF_IDLE : IF_FAULT;
            default:          state_nx = IF_IDLE;
        endcase
    end

    // A write landing in the final READ cycle is the newest, so it beats any latched redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IF_IDLE;
            pc       <= RESET_PC;
            ir       <= 32'd0;
            cnt      <= 3'd0;
            redir    <= 1'b0;
            redir_pc <= 32'd0;
        end else begin
            state <= state_nx;
            cnt   <= (state == IF_READ) ? cnt + 3'd1 : 3'd0;
            if (state == IF_READ) begin
                if (read_last) begin
                    ir    <= rom.rom_data;
                    pc    <= pc_we ? pc_next : redir ? redir_pc : pc_plus4;
                    redir <= 1'b0;
                end else if (pc_we) begin
                    redir    <= 1'b1;
                    redir_pc <= pc_next;
                end
            end else if (pc_we) begin
                pc <= pc_next;
            end
        end
    end

    assign pc_plus4     = pc + PC_INC;
    assign busy         = (state == IF_READ);
    assign ir_valid     = (state == IF_DONE);
    assign fault        = (state == IF_FAULT);
    assign rom.rom_nce  = !busy;
    assign rom.rom_re   = busy;
    assign rom.rom_addr = busy ? pc[ROM_AWIDTH-1:0] : '0;

endmodule
